// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// frame magic, FSM states, error codes and byte-strobe helper.
package imem_loader_pkg;

    localparam int         WORD         = 32;
    localparam logic [7:0] LOADER_MAGIC = 8'hA5;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_CSUM     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR_ADDR = 3'd1,
        ST_HDR_LEN  = 3'd2,
        ST_DATA     = 3'd3,
        ST_CSUM     = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERR      = 3'd6
    } state_t;

    // Byte enables for a word whose highest filled lane is 'lane'.
    function automatic logic [3:0] lane_strb(input logic [1:0] lane);
        case (lane)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            2'd2:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in and word write port out of the loader.
// master = loader side, slave = UART/memory environment side.
interface imem_loader_if #(
    parameter int ADDR = 32
);
    import imem_loader_pkg::*;

    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;

    logic             wr_valid;
    logic             wr_ready;
    logic [ADDR-1:0]  wr_addr;
    logic [WORD-1:0]  wr_data;
    logic [3:0]       wr_strb;

    modport master (
        input  in_valid, in_data, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data, wr_strb
    );

    modport slave (
        output in_valid, in_data, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data, wr_strb
    );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs accepted payload bytes little-endian into a 32-bit word; the word,
// strobe and complete pulse are combinational in the cycle the closing byte arrives.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            byte_vld_i,
    input  logic [7:0]      byte_i,
    input  logic            last_i,
    output logic [WORD-1:0] word_o,
    output logic [3:0]      strb_o,
    output logic            done_o
);

    logic [1:0]  lane_q, lane_d;
    logic [23:0] buf_q,  buf_d;

    // Lanes above the current byte are forced to zero for short final words.
    always_comb begin
        case (lane_q)
            2'd0:    word_o = {24'h0, byte_i};
            2'd1:    word_o = {16'h0, byte_i, buf_q[7:0]};
            2'd2:    word_o = {8'h0, byte_i, buf_q[15:0]};
            default: word_o = {byte_i, buf_q[23:0]};
        endcase
        strb_o = lane_strb(lane_q);
        done_o = byte_vld_i && ((lane_q == 2'd3) || last_i);

        lane_d = lane_q;
        buf_d  = buf_q;
        if (byte_vld_i) begin
            if (done_o) begin
                lane_d = 2'd0;
                buf_d  = 24'h0;
            end else begin
                lane_d = lane_q + 2'd1;
                buf_d  = word_o[23:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= 2'd0;
            buf_q  <= 24'h0;
        end else begin
            lane_q <= lane_d;
            buf_q  <= buf_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses an A5/base/len/payload/csum frame, writes the payload
// into the instruction store and releases cpu_hold once the checksum matches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR = 32,
    parameter int unsigned LEN  = 65535
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.master bus,
    output logic          cpu_hold_o,
    output logic          done_o,
    output logic          err_o,
    output logic [1:0]    err_code_o
);

    state_t          state_q, state_d;
    logic [23:0]     shift_q, shift_d;
    logic [1:0]      hcnt_q, hcnt_d;
    logic [ADDR-1:0] base_q, base_d;
    logic [ADDR-1:0] waddr_q, waddr_d;
    logic [31:0]     rem_q, rem_d;
    logic [7:0]      sum_q, sum_d;
    logic [1:0]      err_code_q, err_code_d;

    logic            wr_valid_q, wr_valid_d;
    logic [ADDR-1:0] wr_addr_q, wr_addr_d;
    logic [WORD-1:0] wr_data_q, wr_data_d;
    logic [3:0]      wr_strb_q, wr_strb_d;

    logic            in_ready, accept;
    logic [31:0]     hdr_word;
    logic [ADDR:0]   end_addr;
    logic            pk_vld, pk_last, pk_done;
    logic [WORD-1:0] pk_word;
    logic [3:0]      pk_strb;

    // A stalled write blocks the stream; that is the only backpressure path.
    assign in_ready = (state_q inside {ST_IDLE, ST_HDR_ADDR, ST_HDR_LEN, ST_DATA, ST_CSUM})
                      && !(wr_valid_q && !bus.wr_ready);
    assign accept   = bus.in_valid && in_ready;
    assign hdr_word = {bus.in_data, shift_q};
    // One bit wider than the address so base+N-1 cannot wrap.
    assign end_addr = {1'b0, base_q} + (ADDR+1)'(hdr_word) - (ADDR+1)'(1);

    assign pk_vld  = accept && (state_q == ST_DATA);
    assign pk_last = (rem_q == 32'd1);

    word_packer u_pack (
        .clk        (clk),
        .rst        (rst),
        .byte_vld_i (pk_vld),
        .byte_i     (bus.in_data),
        .last_i     (pk_last),
        .word_o     (pk_word),
        .strb_o     (pk_strb),
        .done_o     (pk_done)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        hcnt_d     = hcnt_q;
        base_d     = base_q;
        waddr_d    = waddr_q;
        rem_d      = rem_q;
        sum_d      = sum_q;
        err_code_d = err_code_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && (bus.in_data == LOADER_MAGIC)) begin
                    state_d = ST_HDR_ADDR;
                    hcnt_d  = 2'd0;
                    sum_d   = 8'h00;
                end
            end
            ST_HDR_ADDR: begin
                if (accept) begin
                    shift_d = hdr_word[31:8];
                    hcnt_d  = hcnt_q + 2'd1;
                    if (hcnt_q == 2'd3) begin
                        base_d  = ADDR'(hdr_word);
                        state_d = ST_HDR_LEN;
                    end
                end
            end
            ST_HDR_LEN: begin
                if (accept) begin
                    shift_d = hdr_word[31:8];
                    hcnt_d  = hcnt_q + 2'd1;
                    if (hcnt_q == 2'd3) begin
                        rem_d   = hdr_word;
                        waddr_d = base_q;
                        if (base_q[1:0] != 2'b00) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_MISALIGN;
                        end else if ((hdr_word != 32'd0) && (end_addr > (ADDR+1)'(LEN))) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_RANGE;
                        end else if (hdr_word == 32'd0) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    sum_d = sum_q + bus.in_data;
                    rem_d = rem_q - 32'd1;
                    if (rem_q == 32'd1) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                // A pending final write is handshaking in this same cycle,
                // since the byte could not be accepted while it was stalled.
                if (accept) begin
                    if (bus.in_data == sum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_CSUM;
                    end
                end
            end
            default: ;
        endcase

        if (pk_done) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = waddr_q;
            wr_data_d  = pk_word;
            wr_strb_d  = pk_strb;
            waddr_d    = waddr_q + ADDR'(4);
        end else if (wr_valid_q && bus.wr_ready) begin
            wr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            hcnt_q     <= '0;
            base_q     <= '0;
            waddr_q    <= '0;
            rem_q      <= '0;
            sum_q      <= '0;
            err_code_q <= ERR_NONE;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
        end else begin
            shift_q    <= shift_d;
            hcnt_q     <= hcnt_d;
            base_q     <= base_d;
            waddr_q    <= waddr_d;
            rem_q      <= rem_d;
            sum_q      <= sum_d;
            err_code_q <= err_code_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.wr_strb  = wr_strb_q;

    assign done_o     = (state_q == ST_DONE);
    assign err_o      = (state_q == ST_ERR);
    assign cpu_hold_o = (state_q != ST_DONE);
    assign err_code_o = err_code_q;

endmodule
